// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one single-port synchronous memory between the core's
//   MemoryController and an external requester (debug / program loader).
//   Per-cycle arbitration favouring the core, a starvation counter that
//   bounds the external wait, and a core lock that keeps a two-cycle store
//   sequence atomic.
//
// Ports
//   clock, reset                 clock and async active-high reset
//   core*  (Req/Write/Lock/Addr/WriteData/ByteEnable)  core request side
//   coreGrant/coreStall/coreReadValid                  core response side
//   ext*   (Req/Write/Addr/WriteData/ByteEnable)       external request side
//   extGrant/extReadValid                              external response side
//   readData                     shared read data (= memReadData)
//   mem*                         memory array port
//
// lastOwner states
//   state    | meaning
//   OWN_IDLE | nobody was granted last cycle
//   OWN_CORE | core was granted last cycle (lock may hold the bus)
//   OWN_EXT  | external requester was granted last cycle
module memory_port_arbiter #(
  parameter int ADDR_WIDTH     = 30,
  parameter int MAX_CORE_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  coreReq,
  input  logic                  coreWrite,
  input  logic                  coreLock,
  input  logic [ADDR_WIDTH-1:0] coreAddr,
  input  logic [31:0]           coreWriteData,
  input  logic [3:0]            coreByteEnable,
  output logic                  coreGrant,
  output logic                  coreStall,
  output logic                  coreReadValid,
  input  logic                  extReq,
  input  logic                  extWrite,
  input  logic [ADDR_WIDTH-1:0] extAddr,
  input  logic [31:0]           extWriteData,
  input  logic [3:0]            extByteEnable,
  output logic                  extGrant,
  output logic                  extReadValid,
  output logic [31:0]           readData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWriteData,
  output logic [3:0]            memByteEnable,
  output logic                  memWriteEnable,
  input  logic [31:0]           memReadData
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_CORE_BURST);

  owner_e     last_owner_q, last_owner_d;
  logic [3:0] starve_q, starve_d;
  logic       core_rv_q, core_rv_d;
  logic       ext_rv_q, ext_rv_d;
  logic       core_gnt, ext_gnt;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_IDLE;
      starve_q     <= '0;
      core_rv_q    <= 1'b0;
      ext_rv_q     <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      starve_q     <= starve_d;
      core_rv_q    <= core_rv_d;
      ext_rv_q     <= ext_rv_d;
    end
  end

  // Next-state logic
  always_comb begin
    last_owner_d = OWN_IDLE;
    if (core_gnt) begin
      last_owner_d = OWN_CORE;
    end else if (ext_gnt) begin
      last_owner_d = OWN_EXT;
    end

    // Keeps saturating through a locked core sequence so the external
    // requester wins on the first contended cycle after the lock drops.
    starve_d = starve_q;
    if (extReq && core_gnt) begin
      if (starve_q < BURST_MAX) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (ext_gnt || !extReq) begin
      starve_d = '0;
    end

    core_rv_d = core_gnt & ~coreWrite;
    ext_rv_d  = ext_gnt & ~extWrite;
  end

  // Output logic: grant decision and memory port mux
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (!reset) begin
      if (last_owner_q == OWN_CORE && coreLock) begin
        // Lock holds the bus even if the core does not access this cycle.
        core_gnt = coreReq;
      end else if (coreReq && extReq) begin
        ext_gnt  = (starve_q == BURST_MAX);
        core_gnt = ~ext_gnt;
      end else begin
        core_gnt = coreReq;
        ext_gnt  = extReq;
      end
    end

    memAddr        = '0;
    memWriteData   = '0;
    memByteEnable  = '0;
    memWriteEnable = 1'b0;
    if (core_gnt) begin
      memAddr        = coreAddr;
      memWriteData   = coreWriteData;
      memByteEnable  = coreByteEnable;
      memWriteEnable = coreWrite;
    end else if (ext_gnt) begin
      memAddr        = extAddr;
      memWriteData   = extWriteData;
      memByteEnable  = extByteEnable;
      memWriteEnable = extWrite;
    end
  end

  assign coreGrant     = core_gnt;
  assign extGrant      = ext_gnt;
  assign coreStall     = coreReq & ~core_gnt;
  assign coreReadValid = core_rv_q;
  assign extReadValid  = ext_rv_q;
  assign readData      = memReadData;

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
  localparam int AW    = 30;
  localparam int MAXB  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          coreReq, coreWrite, coreLock;
  logic [AW-1:0] coreAddr;
  logic [31:0]   coreWriteData;
  logic [3:0]    coreByteEnable;
  logic          coreGrant, coreStall, coreReadValid;
  logic          extReq, extWrite;
  logic [AW-1:0] extAddr;
  logic [31:0]   extWriteData;
  logic [3:0]    extByteEnable;
  logic          extGrant, extReadValid;
  logic [31:0]   readData;
  logic [AW-1:0] memAddr;
  logic [31:0]   memWriteData;
  logic [3:0]    memByteEnable;
  logic          memWriteEnable;
  logic [31:0]   memReadData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .MAX_CORE_BURST(MAXB)) dut (
    .clock(clk), .reset(reset),
    .coreReq(coreReq), .coreWrite(coreWrite), .coreLock(coreLock),
    .coreAddr(coreAddr), .coreWriteData(coreWriteData), .coreByteEnable(coreByteEnable),
    .coreGrant(coreGrant), .coreStall(coreStall), .coreReadValid(coreReadValid),
    .extReq(extReq), .extWrite(extWrite), .extAddr(extAddr),
    .extWriteData(extWriteData), .extByteEnable(extByteEnable),
    .extGrant(extGrant), .extReadValid(extReadValid),
    .readData(readData),
    .memAddr(memAddr), .memWriteData(memWriteData), .memByteEnable(memByteEnable),
    .memWriteEnable(memWriteEnable), .memReadData(memReadData)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAABBCCDD;
    return 32'h5A00_0000 ^ (i * 32'h0001_0307);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory array seen by the DUT
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      memReadData <= mem[memAddr[7:0]];
      if (memWriteEnable) mem[memAddr[7:0]] = merge(mem[memAddr[7:0]], memWriteData, memByteEnable);
    end
  end

  // Behavioural reference: who was granted last, how long ext has waited,
  // pending read results and a shadow copy of memory contents.
  int          m_owner = 0;      // 0 none, 1 core, 2 ext
  int          m_wait  = 0;
  bit          m_crv = 1'b0, m_erv = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] shadow [256];

  function automatic void calc(output bit cg, output bit eg);
    cg = 1'b0;
    eg = 1'b0;
    if (reset) return;
    if (m_owner == 1 && coreLock) begin
      cg = coreReq;
    end else if (coreReq && extReq) begin
      eg = (m_wait == MAXB);
      cg = !eg;
    end else begin
      cg = coreReq;
      eg = extReq;
    end
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    forever begin
      bit cg, eg;
      @(posedge clk);
      calc(cg, eg);
      if (reset) begin
        m_owner = 0; m_wait = 0; m_crv = 0; m_erv = 0;
      end else begin
        if (extReq && cg) m_wait = (m_wait + 1 > MAXB) ? MAXB : m_wait + 1;
        else if (eg || !extReq) m_wait = 0;
        m_owner = cg ? 1 : (eg ? 2 : 0);
        m_crv = cg && !coreWrite;
        m_erv = eg && !extWrite;
        if (cg) begin
          m_rdata = shadow[coreAddr[7:0]];
          if (coreWrite) shadow[coreAddr[7:0]] = merge(shadow[coreAddr[7:0]], coreWriteData, coreByteEnable);
        end else if (eg) begin
          m_rdata = shadow[extAddr[7:0]];
          if (extWrite) shadow[extAddr[7:0]] = merge(shadow[extAddr[7:0]], extWriteData, extByteEnable);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit cg, eg;
    logic [AW-1:0] ea;
    logic [31:0]   ewd;
    logic [3:0]    ebe;
    logic          ewe;
    calc(cg, eg);
    ea = '0; ewd = '0; ebe = '0; ewe = 1'b0;
    if (cg) begin
      ea = coreAddr; ewd = coreWriteData; ebe = coreByteEnable; ewe = coreWrite;
    end else if (eg) begin
      ea = extAddr; ewd = extWriteData; ebe = extByteEnable; ewe = extWrite;
    end
    chk("coreGrant", 32'(coreGrant), 32'(cg));
    chk("extGrant", 32'(extGrant), 32'(eg));
    chk("coreStall", 32'(coreStall), 32'(coreReq & ~cg));
    chk("memAddr", 32'(memAddr), 32'(ea));
    chk("memWriteData", memWriteData, ewd);
    chk("memByteEnable", 32'(memByteEnable), 32'(ebe));
    chk("memWriteEnable", 32'(memWriteEnable), 32'(ewe));
    chk("coreReadValid", 32'(coreReadValid), reset ? 32'd0 : 32'(m_crv));
    chk("extReadValid", 32'(extReadValid), reset ? 32'd0 : 32'(m_erv));
    if (!reset && (m_crv || m_erv)) chk("readData", readData, m_rdata);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr();
    coreReq = 0; coreWrite = 0; coreLock = 0; coreAddr = '0;
    coreWriteData = '0; coreByteEnable = '0;
    extReq = 0; extWrite = 0; extAddr = '0; extWriteData = '0; extByteEnable = '0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    nxt(); nxt();
    reset = 1'b0;
    smp();

    // Core read of 0x10
    nxt(); clr(); coreReq = 1; coreAddr = 30'h10; coreByteEnable = 4'hF;
    smp(); chk("t_read_grant", 32'(coreGrant), 32'd1);
    nxt(); clr();
    smp();
    chk("t_read_valid", 32'(coreReadValid), 32'd1);
    chk("t_read_data", readData, 32'hDEADBEEF);
    chk("t_read_extvalid", 32'(extReadValid), 32'd0);

    // Contention: C C C C E repeating
    nxt(); clr(); smp();
    for (int i = 0; i < 10; i++) begin
      nxt(); clr();
      coreReq = 1; coreAddr = AW'(i); extReq = 1; extAddr = 30'h40;
      smp();
      chk("t_cont_ext", 32'(extGrant), (i % 5 == 4) ? 32'd1 : 32'd0);
      chk("t_cont_stall", 32'(coreStall), (i % 5 == 4) ? 32'd1 : 32'd0);
    end

    // Lock atomicity with saturated counter
    for (int j = 0; j < 8; j++) begin
      nxt(); clr();
      coreReq = 1; coreAddr = AW'(j); extReq = 1; extAddr = 30'h41;
      coreLock = (j >= 4 && j <= 6);
      smp();
      if (j >= 4 && j <= 6) chk("t_lock_ext", 32'(extGrant), 32'd0);
      if (j == 7) chk("t_lock_release", 32'(extGrant), 32'd1);
    end

    // Lock ignored from IDLE
    nxt(); clr(); coreLock = 1; smp();
    nxt(); clr(); coreLock = 1; extReq = 1; extAddr = 30'h42; smp();
    chk("t_idle_lock", 32'(extGrant), 32'd1);

    // Ext byte write then core read-back
    nxt(); clr(); extReq = 1; extWrite = 1; extAddr = 30'h20;
    extWriteData = 32'h12345678; extByteEnable = 4'b0011;
    smp();
    chk("t_wr_we", 32'(memWriteEnable), 32'd1);
    chk("t_wr_be", 32'(memByteEnable), 32'h3);
    nxt(); clr(); coreReq = 1; coreAddr = 30'h20; smp();
    nxt(); clr(); smp();
    chk("t_wr_valid", 32'(coreReadValid), 32'd1);
    chk("t_wr_data", readData, 32'hAABB5678);

    // Reset mid-read and mid-lock
    nxt(); clr(); coreReq = 1; coreLock = 1; coreAddr = 30'h10; smp();
    chk("t_rst_grant", 32'(coreGrant), 32'd1);
    nxt(); reset = 1; smp();
    chk("t_rst_valid", 32'(coreReadValid), 32'd0);
    chk("t_rst_grant0", 32'(coreGrant), 32'd0);
    nxt(); smp();
    nxt(); reset = 0; clr(); coreLock = 1; extReq = 1; extAddr = 30'h43; smp();
    chk("t_rst_idle", 32'(extGrant), 32'd1);
    chk("t_rst_novalid", 32'(coreReadValid), 32'd0);
    nxt(); clr(); smp();
    chk("t_rst_novalid2", 32'(coreReadValid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset          = ($urandom_range(199) == 0);
      coreReq        = ($urandom_range(9) < 7);
      coreWrite      = $urandom_range(1);
      coreLock       = $urandom_range(1);
      coreAddr       = AW'($urandom_range(255));
      coreWriteData  = $urandom;
      coreByteEnable = 4'($urandom_range(15));
      extReq         = $urandom_range(1);
      extWrite       = $urandom_range(1);
      extAddr        = AW'($urandom_range(255));
      extWriteData   = $urandom;
      extByteEnable  = 4'($urandom_range(15));
      smp();
    end

    nxt(); reset = 0; clr(); smp();
    nxt(); smp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
